// File: rtl/div_arbiter_if.sv
// Requester and divider signal bundle for div_arbiter.
//   slave  : the arbiter's view (requests and divider results in; acks, results, divider control out)
//   master : the surrounding logic's view (directions reversed)
`timescale 1ns/1ps
interface div_arbiter_if;
    // requester side
    logic       req0;
    logic       req1;
    logic [3:0] dividend0;
    logic [3:0] dividend1;
    logic [4:0] divisor0;
    logic [4:0] divisor1;
    logic       ack0;
    logic       ack1;
    logic       done0;
    logic       done1;
    logic [3:0] quotient;
    logic [4:0] remainder;
    logic       err;
    logic       busy;
    // divider side
    logic       div_go;
    logic [3:0] div_dividend;
    logic [4:0] div_divisor;
    logic       div_valid;
    logic [3:0] div_quotient;
    logic [4:0] div_remainder;

    modport slave (
        input  req0, req1, dividend0, dividend1, divisor0, divisor1,
        input  div_valid, div_quotient, div_remainder,
        output ack0, ack1, done0, done1, quotient, remainder, err, busy,
        output div_go, div_dividend, div_divisor
    );

    modport master (
        output req0, req1, dividend0, dividend1, divisor0, divisor1,
        output div_valid, div_quotient, div_remainder,
        input  ack0, ack1, done0, done1, quotient, remainder, err, busy,
        input  div_go, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative 4-bit / 5-bit divider
// between two requesters. Divide-by-zero is answered locally; a watchdog
// forces an error completion if the divider never reports valid.
// Ports:
//   clk     : clock, rising edge
//   resetn  : synchronous active-low reset (shared with the divider)
//   bus     : div_arbiter_if.slave -- requests/operands in, ack/done/result out,
//             divider go/operands out, divider valid/result in
// Parameter TIMEOUT: cycles allowed in WAIT_LOW+WAIT_HIGH, legal 2..255.
`timescale 1ns/1ps
module div_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         resetn,
    div_arbiter_if.slave bus
);
    localparam int unsigned   WD_W    = 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        RESP
    } state_t;

    state_t          state;
    logic            owner;
    logic            last_owner;
    logic [3:0]      op_dividend;
    logic [4:0]      op_divisor;
    logic [WD_W-1:0] wd_cnt;

    logic            pick_c;
    logic [3:0]      pick_dividend_c;
    logic [4:0]      pick_divisor_c;
    logic            wd_expired_c;

    // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
    always_comb begin
        pick_c = bus.req1;
        if (bus.req0 && bus.req1) begin
            pick_c = ~last_owner;
        end
        pick_dividend_c = pick_c ? bus.dividend1 : bus.dividend0;
        pick_divisor_c  = pick_c ? bus.divisor1  : bus.divisor0;
    end

    assign wd_expired_c = (wd_cnt == WD_LAST);

    // Divider operands come straight from the op registers, stable for the whole operation.
    assign bus.div_dividend = op_dividend;
    assign bus.div_divisor  = op_divisor;

    // Sequencer: all outputs are registered and set on the edge entering the state they belong to.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_owner    <= 1'b1;
            op_dividend   <= '0;
            op_divisor    <= '0;
            wd_cnt        <= '0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.div_go    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
        end else begin
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.done0  <= 1'b0;
            bus.done1  <= 1'b0;
            bus.div_go <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner       <= pick_c;
                        op_dividend <= pick_dividend_c;
                        op_divisor  <= pick_divisor_c;
                        bus.ack0    <= ~pick_c;
                        bus.ack1    <= pick_c;
                        bus.div_go  <= (pick_divisor_c != 5'd0);
                        bus.busy    <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    last_owner <= owner;
                    wd_cnt     <= '0;
                    if (op_divisor != 5'd0) begin
                        state <= WAIT_LOW;
                    end else begin
                        // Divide-by-zero: answer locally, divider never started.
                        bus.quotient  <= 4'hF;
                        bus.remainder <= {1'b0, op_dividend};
                        bus.err       <= 1'b1;
                        bus.done0     <= ~owner;
                        bus.done1     <= owner;
                        state         <= RESP;
                    end
                end

                // Wait out any valid still asserted from the previous operation.
                WAIT_LOW: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (!bus.div_valid) begin
                        state <= WAIT_HIGH;
                    end else if (wd_expired_c) begin
                        bus.quotient  <= '0;
                        bus.remainder <= '0;
                        bus.err       <= 1'b1;
                        bus.done0     <= ~owner;
                        bus.done1     <= owner;
                        state         <= RESP;
                    end
                end

                // A valid result takes priority over a watchdog expiring on the same edge.
                WAIT_HIGH: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (bus.div_valid) begin
                        bus.quotient  <= bus.div_quotient;
                        bus.remainder <= bus.div_remainder;
                        bus.err       <= 1'b0;
                        bus.done0     <= ~owner;
                        bus.done1     <= owner;
                        state         <= RESP;
                    end else if (wd_expired_c) begin
                        bus.quotient  <= '0;
                        bus.remainder <= '0;
                        bus.err       <= 1'b1;
                        bus.done0     <= ~owner;
                        bus.done1     <= owner;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
